// File: rtl/z80_bus_ctrl.sv
// Z80 bus controller: SRAM strobes with optional wait states, I/O port block.
// Wait-state register and WAIT state exist only with BUS_CTRL_WAIT_STATES_EN.
module z80_bus_ctrl #(
  parameter logic [2:0] WS_RESET = 3'd0,
  parameter logic [7:0] IO_BASE  = 8'h10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_do,
  output logic [7:0]  cpu_di,
  input  logic        cpu_mreq_n,
  input  logic        cpu_iorq_n,
  input  logic        cpu_rd_n,
  input  logic        cpu_wr_n,
  input  logic        cpu_m1_n,
  input  logic        cpu_rfsh_n,
  output logic        cpu_wait_n,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        mem_re,
  output logic        mem_we,
  output logic [31:0] io_out,
  input  logic [7:0]  io_in
);

`ifdef BUS_CTRL_WAIT_STATES_EN
  typedef enum logic [1:0] {
    S_IDLE, S_ACCESS, S_WAIT, S_HOLD
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_ACCESS, S_HOLD
  } state_t;
`endif

  state_t r_state, w_next;

  logic        r_armed;
  logic        r_mem_re, r_mem_we;
  logic [15:0] r_mem_addr;
  logic [7:0]  r_mem_wdata;
  logic        r_pend;
  logic [7:0]  r_mem_rd;
  logic [7:0]  r_io_rd;
  logic [31:0] r_io_out;

  logic w_mem_rd, w_mem_wr, w_mem;
  logic w_io, w_iord, w_iowr, w_inta;
  logic w_start, w_go_mem, w_go_io;
  logic [7:0] w_off;
  logic [7:0] w_io_rdval;
  logic [7:0] w_ws_rd;

  // memory wins when mreq_n and iorq_n collide
  assign w_mem_rd = !cpu_mreq_n && !cpu_rd_n && cpu_rfsh_n;
  assign w_mem_wr = !cpu_mreq_n && !cpu_wr_n;
  assign w_mem    = w_mem_rd || w_mem_wr;
  assign w_io     = cpu_mreq_n && !cpu_iorq_n && cpu_m1_n;
  assign w_iord   = w_io && !cpu_rd_n;
  assign w_iowr   = w_io && cpu_rd_n && !cpu_wr_n;
  assign w_inta   = cpu_mreq_n && !cpu_iorq_n && !cpu_m1_n;

  assign w_start  = (r_state == S_IDLE) && r_armed;
  assign w_go_mem = w_start && w_mem;
  assign w_go_io  = w_start && (w_iord || w_iowr);
  assign w_off    = cpu_a[7:0] - IO_BASE;

`ifdef BUS_CTRL_WAIT_STATES_EN
  logic [2:0] r_ws;
  logic [2:0] r_cnt;
  assign w_ws_rd    = {5'b0, r_ws};
  assign cpu_wait_n = (r_state != S_WAIT);
`else
  // fixed zero wait; the register location reads as all ones
  assign w_ws_rd    = 8'hFF | {5'b0, WS_RESET};
  assign cpu_wait_n = 1'b1;
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_start) begin
          if (w_mem)
            w_next = S_ACCESS;
          else if (w_iord || w_iowr || w_inta)
            w_next = S_HOLD;
        end
      end
`ifdef BUS_CTRL_WAIT_STATES_EN
      S_ACCESS:
        w_next = (r_cnt != 3'd0) ? S_WAIT : S_HOLD;
      S_WAIT:
        if (r_cnt == 3'd1) w_next = S_HOLD;
`else
      S_ACCESS:
        w_next = S_HOLD;
`endif
      S_HOLD:
        if (cpu_mreq_n && cpu_iorq_n) w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_io_rdval = 8'hFF;
    case (w_off)
      8'd0, 8'd1, 8'd2, 8'd3:
        w_io_rdval = r_io_out[{w_off[1:0], 3'b000} +: 8];
      8'd4:    w_io_rdval = io_in;
      8'd15:   w_io_rdval = w_ws_rd;
      default: w_io_rdval = 8'hFF;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_armed     <= 1'b0;
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 16'h0000;
      r_mem_wdata <= 8'h00;
      r_pend      <= 1'b0;
      r_mem_rd    <= 8'h00;
      r_io_rd     <= 8'h00;
      r_io_out    <= 32'h0;
    end else begin
      r_state  <= w_next;
      // a strobe held through reset must drop before it counts
      if (cpu_mreq_n && cpu_iorq_n) r_armed <= 1'b1;
      r_mem_re <= w_go_mem && w_mem_rd;
      r_mem_we <= w_go_mem && w_mem_wr && !w_mem_rd;
      if (w_go_mem) r_mem_addr <= cpu_a;
      if (w_go_mem && w_mem_wr && !w_mem_rd)
        r_mem_wdata <= cpu_do;
      r_pend <= r_mem_re;
      if (r_pend) r_mem_rd <= mem_rdata;
      if (w_go_io && w_iord) r_io_rd <= w_io_rdval;
      if (w_go_io && w_iowr && (w_off < 8'd4))
        r_io_out[{w_off[1:0], 3'b000} +: 8] <= cpu_do;
    end
  end

`ifdef BUS_CTRL_WAIT_STATES_EN
  // count is sampled at access start so ws writes never disturb it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ws  <= WS_RESET;
      r_cnt <= 3'd0;
    end else begin
      if (w_go_io && w_iowr && (w_off == 8'd15))
        r_ws <= cpu_do[2:0];
      if (w_go_mem)
        r_cnt <= r_ws;
      else if (r_state == S_WAIT)
        r_cnt <= r_cnt - 3'd1;
    end
  end
`endif

  assign mem_re    = r_mem_re;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign io_out    = r_io_out;
  assign cpu_di    = !cpu_iorq_n
                   ? (!cpu_m1_n ? 8'hFF : r_io_rd)
                   : r_mem_rd;

endmodule

// File: tb/tb_z80_bus_ctrl.sv
// Directed bench for z80_bus_ctrl: emulates Z80 bus cycles and an SRAM.
// Expectations follow BUS_CTRL_WAIT_STATES_EN when the bench is built with it.
module tb_z80_bus_ctrl;

`ifdef BUS_CTRL_WAIT_STATES_EN
  localparam int       EXP_WAIT  = 3;
  localparam bit [7:0] EXP_WS3   = 8'h03;
  localparam bit [7:0] EXP_WSRST = 8'h00;
`else
  localparam int       EXP_WAIT  = 0;
  localparam bit [7:0] EXP_WS3   = 8'hFF;
  localparam bit [7:0] EXP_WSRST = 8'hFF;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] cpu_a = 16'h0;
  logic [7:0]  cpu_do = 8'h0;
  logic [7:0]  cpu_di;
  logic        cpu_mreq_n = 1'b1;
  logic        cpu_iorq_n = 1'b1;
  logic        cpu_rd_n = 1'b1;
  logic        cpu_wr_n = 1'b1;
  logic        cpu_m1_n = 1'b1;
  logic        cpu_rfsh_n = 1'b1;
  logic        cpu_wait_n;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h0;
  logic        mem_re, mem_we;
  logic [31:0] io_out;
  logic [7:0]  io_in = 8'h0;

  logic        ld_en = 1'b0;
  logic [15:0] ld_addr = 16'h0;
  logic [7:0]  ld_data = 8'h0;
  logic [7:0]  sram [0:65535];

  int n_re = 0, n_we = 0, n_wait = 0;
  int n_cmp = 0, n_bad = 0;

  z80_bus_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_a(cpu_a), .cpu_do(cpu_do), .cpu_di(cpu_di),
    .cpu_mreq_n(cpu_mreq_n), .cpu_iorq_n(cpu_iorq_n),
    .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n),
    .cpu_m1_n(cpu_m1_n), .cpu_rfsh_n(cpu_rfsh_n),
    .cpu_wait_n(cpu_wait_n),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_re(mem_re), .mem_we(mem_we),
    .io_out(io_out), .io_in(io_in)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld_en) sram[ld_addr] <= ld_data;
    else if (mem_we) sram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= sram[mem_addr];
  end

  always @(posedge clk) begin
    if (mem_re) n_re <= n_re + 1;
    if (mem_we) n_we <= n_we + 1;
    if (!cpu_wait_n) n_wait <= n_wait + 1;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus();
    cpu_mreq_n = 1'b1; cpu_iorq_n = 1'b1;
    cpu_rd_n = 1'b1; cpu_wr_n = 1'b1;
    cpu_m1_n = 1'b1; cpu_rfsh_n = 1'b1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic mem_rd(input logic [15:0] a, input bit m1,
                        output logic [7:0] d);
    int g;
    @(negedge clk);
    cpu_a = a; cpu_m1_n = !m1;
    cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0;
    repeat (2) @(negedge clk);
    g = 0;
    while (!cpu_wait_n && g < 20) begin
      @(negedge clk);
      g++;
    end
    check("wait_bound", 32'(g < 20), 32'd1);
    @(negedge clk);
    d = cpu_di;
    idle_bus();
    @(negedge clk);
  endtask

  task automatic mem_wr(input logic [15:0] a, input logic [7:0] v);
    int g;
    @(negedge clk);
    cpu_a = a; cpu_do = v;
    cpu_mreq_n = 1'b0; cpu_wr_n = 1'b0;
    repeat (2) @(negedge clk);
    g = 0;
    while (!cpu_wait_n && g < 20) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    idle_bus();
    @(negedge clk);
  endtask

  task automatic refresh(input logic [15:0] a);
    @(negedge clk);
    cpu_a = a; cpu_mreq_n = 1'b0; cpu_rfsh_n = 1'b0;
    repeat (2) @(negedge clk);
    idle_bus();
    @(negedge clk);
  endtask

  task automatic io_wr(input logic [15:0] a, input logic [7:0] v);
    @(negedge clk);
    cpu_a = a; cpu_do = v;
    cpu_iorq_n = 1'b0; cpu_wr_n = 1'b0;
    repeat (3) @(negedge clk);
    idle_bus();
    @(negedge clk);
  endtask

  task automatic io_rd(input logic [15:0] a, output logic [7:0] d);
    @(negedge clk);
    cpu_a = a; cpu_iorq_n = 1'b0; cpu_rd_n = 1'b0;
    repeat (2) @(negedge clk);
    d = cpu_di;
    idle_bus();
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] d;
    int re0, we0, w0;

    preload(16'h0000, 8'h06);
    preload(16'h0001, 8'hBC);
    preload(16'h8000, 8'h77);
    @(negedge clk);
    check("rst_wait_n", 32'(cpu_wait_n), 32'd1);
    check("rst_mem_re", 32'(mem_re), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_io_out", io_out, 32'h0);
    check("rst_cpu_di", 32'(cpu_di), 32'h0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // LD B,BCh: opcode fetch + refresh, then operand read
    re0 = n_re;
    mem_rd(16'h0000, 1'b1, d);
    check("fetch_op", 32'(d), 32'h06);
    w0 = n_re;
    refresh(16'h0000);
    check("rfsh_no_re", 32'(n_re - w0), 32'd0);
    mem_rd(16'h0001, 1'b0, d);
    check("ld_b_val", 32'(d), 32'hBC);
    check("ld_re_cnt", 32'(n_re - re0), 32'd2);
    check("ld_last_addr", 32'(mem_addr), 32'h0001);

    // OUT (10h),A with A=5A
    we0 = n_we;
    io_wr(16'h5A10, 8'h5A);
    check("out10_io", io_out, 32'h0000005A);
    check("out10_no_we", 32'(n_we - we0), 32'd0);

    // OUT (1Fh),3 then LD A,(8000h)
    io_wr(16'h031F, 8'h03);
    io_rd(16'h001F, d);
    check("ws_read", 32'(d), 32'(EXP_WS3));
    w0 = n_wait;
    mem_rd(16'h8000, 1'b0, d);
    check("ld_a_wait", 32'(n_wait - w0), 32'(EXP_WAIT));
    check("ld_a_val", 32'(d), 32'h77);

    // I/O reads
    io_in = 8'hC3;
    io_rd(16'h0014, d);
    check("in14", 32'(d), 32'hC3);
    io_rd(16'h0020, d);
    check("in20", 32'(d), 32'hFF);
    io_rd(16'h0010, d);
    check("in10", 32'(d), 32'h5A);

    // interrupt acknowledge
    @(negedge clk);
    cpu_iorq_n = 1'b0; cpu_m1_n = 1'b0;
    @(negedge clk);
    check("inta_di", 32'(cpu_di), 32'hFF);
    idle_bus();
    @(negedge clk);
    check("inta_io", io_out, 32'h0000005A);

    // memory write then read-back
    we0 = n_we;
    mem_wr(16'h4000, 8'h99);
    check("wr_we_cnt", 32'(n_we - we0), 32'd1);
    mem_rd(16'h4000, 1'b0, d);
    check("wr_readback", 32'(d), 32'h99);

    // reset in the middle of a waited read
    @(negedge clk);
    cpu_a = 16'h8000; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_wait_n", 32'(cpu_wait_n), 32'(EXP_WAIT == 0));
    #2 reset_n = 1'b0;
    #1;
    check("rst_async_wait", 32'(cpu_wait_n), 32'd1);
    check("rst_async_io", io_out, 32'h0);
    check("rst_async_re", 32'(mem_re), 32'd0);
    idle_bus();
    re0 = n_re;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_no_re", 32'(n_re - re0), 32'd0);
    io_rd(16'h001F, d);
    check("rst_ws", 32'(d), 32'(EXP_WSRST));

    // mreq_n and iorq_n together: memory write wins
    we0 = n_we;
    @(negedge clk);
    cpu_a = 16'h0010; cpu_do = 8'h33;
    cpu_mreq_n = 1'b0; cpu_iorq_n = 1'b0; cpu_wr_n = 1'b0;
    repeat (3) @(negedge clk);
    idle_bus();
    repeat (2) @(negedge clk);
    check("coll_we_cnt", 32'(n_we - we0), 32'd1);
    check("coll_io", io_out, 32'h0);
    check("coll_addr", 32'(mem_addr), 32'h0010);
    check("coll_wdata", 32'(mem_wdata), 32'h33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
